// File: rtl/lc3_pipe_if.sv
// lc3_pipe_if
//   Bundles the signals between the LC-3 pipeline sequencer and the datapath.
//   master : the sequencer. It samples the execute-stage instruction, the
//            condition codes and the memory handshake, and it drives the
//            stage enables, br_taken and mem_state.
//   slave  : the datapath side, which is the mirror image of master.
//   Signals:
//     ir_e[15:0], nzp_e[2:0], psr[2:0], complete_data       datapath -> sequencer
//     enable_updatePC/fetch/decode/execute/writeback,
//     br_taken, mem_state[1:0]                              sequencer -> datapath
interface lc3_pipe_if;
  logic [15:0] ir_e;
  logic [2:0]  nzp_e;
  logic [2:0]  psr;
  logic        complete_data;
  logic        enable_updatePC;
  logic        enable_fetch;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  logic        br_taken;
  logic [1:0]  mem_state;

  modport master (
    input  ir_e, nzp_e, psr, complete_data,
    output enable_updatePC, enable_fetch, enable_decode, enable_execute,
           enable_writeback, br_taken, mem_state
  );

  modport slave (
    output ir_e, nzp_e, psr, complete_data,
    input  enable_updatePC, enable_fetch, enable_decode, enable_execute,
           enable_writeback, br_taken, mem_state
  );
endinterface

// File: rtl/lc3_pipe_controller.sv
// lc3_pipe_controller
//   Central sequencer for the five-stage LC-3 pipeline. It fills the pipe
//   after reset. It freezes the pipe while a memory-access instruction walks
//   the data-memory unit through its read, indirect and write states. It also
//   freezes fetch and decode for BR_BUBBLES cycles while a BR or JMP resolves.
//   Ports:
//     clock  : system clock, rising edge
//     reset  : synchronous, active-high
//     pipe   : lc3_pipe_if.master (instruction, condition codes, memory
//              handshake in; stage enables, br_taken, mem_state out)
//   Every output is a flop. The values loaded at an edge come from the state
//   and the inputs sampled at that edge. Input-dependent events therefore
//   show up one cycle after the inputs are sampled: the writeback pulse when
//   a read completes, and br_taken.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   FILL  | pipeline fill after reset, stages switched on one per cycle
//   RUN   | all stages enabled, instruction in execute is classified
//   MEM   | pipe frozen, data-memory access walks READ/INDIRECT/WRITE/IDLE
//   BRW   | fetch/decode frozen while a BR/JMP resolves
module lc3_pipe_controller #(
  parameter int unsigned BR_BUBBLES = 2
) (
  input logic         clock,
  input logic         reset,
  lc3_pipe_if.master  pipe
);

  typedef enum logic [1:0] {FILL, RUN, MEM, BRW} state_t;

  localparam logic [1:0] MS_READ  = 2'd0;
  localparam logic [1:0] MS_IND   = 2'd1;
  localparam logic [1:0] MS_WRITE = 2'd2;
  localparam logic [1:0] MS_IDLE  = 2'd3;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;

  localparam logic [2:0] BR_LOAD = 3'(BR_BUBBLES);

  // Enable vectors are packed {updatePC, fetch, decode, execute, writeback}.
  localparam logic [4:0] EN_ALL  = 5'b11111;
  localparam logic [4:0] EN_NONE = 5'b00000;

  state_t     state_q, state_d;
  logic [1:0] fill_cnt_q, fill_cnt_d;
  logic [2:0] br_cnt_q, br_cnt_d;
  logic       ind_store_q, ind_store_d;
  logic [4:0] en_q, en_d;
  logic       br_q, br_d;
  logic [1:0] mem_q, mem_d;

  logic [3:0] opcode;
  logic       taken;

  assign opcode = pipe.ir_e[15:12];
  assign taken  = |(pipe.nzp_e & pipe.psr);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FILL;
      fill_cnt_q  <= 2'd0;
      br_cnt_q    <= 3'd0;
      ind_store_q <= 1'b0;
      en_q        <= EN_NONE;
      br_q        <= 1'b0;
      mem_q       <= MS_IDLE;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      br_cnt_q    <= br_cnt_d;
      ind_store_q <= ind_store_d;
      en_q        <= en_d;
      br_q        <= br_d;
      mem_q       <= mem_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    br_cnt_d    = br_cnt_q;
    ind_store_d = ind_store_q;
    en_d        = EN_NONE;
    br_d        = 1'b0;
    mem_d       = MS_IDLE;

    case (state_q)
      FILL: begin
        // fill_cnt_q holds the fill step (k) whose enables are loaded at this edge.
        en_d = {1'b1, 1'b1, fill_cnt_q >= 2'd1, fill_cnt_q >= 2'd2, fill_cnt_q == 2'd3};
        if (fill_cnt_q == 2'd3) state_d = RUN;
        else                    fill_cnt_d = fill_cnt_q + 2'd1;
      end

      RUN: begin
        en_d = EN_ALL;
        if (en_q[1]) begin
          case (opcode)
            OP_LD, OP_LDR: begin
              state_d = MEM;
              en_d    = EN_NONE;
              mem_d   = MS_READ;
            end
            OP_ST, OP_STR: begin
              state_d = MEM;
              en_d    = EN_NONE;
              mem_d   = MS_WRITE;
            end
            OP_LDI, OP_STI: begin
              state_d     = MEM;
              en_d        = EN_NONE;
              mem_d       = MS_IND;
              ind_store_d = (opcode == OP_STI);
            end
            OP_BR, OP_JMP: begin
              state_d  = BRW;
              br_cnt_d = BR_LOAD;
              en_d     = 5'b00001;
              // With a single bubble the entry cycle is already the resolve cycle.
              if (BR_LOAD == 3'd1) begin
                en_d[4] = 1'b1;
                br_d    = taken;
              end
            end
            default: ;
          endcase
        end
      end

      MEM: begin
        mem_d = mem_q;
        case (mem_q)
          MS_READ: if (pipe.complete_data) begin
            mem_d   = MS_IDLE;
            en_d[0] = 1'b1;
          end
          MS_WRITE: if (pipe.complete_data) mem_d = MS_IDLE;
          MS_IND: if (pipe.complete_data) mem_d = ind_store_q ? MS_WRITE : MS_READ;
          default: begin
            // IDLE is the one-cycle tail of an access; a stray handshake here is ignored.
            state_d = RUN;
            en_d    = EN_ALL;
            mem_d   = MS_IDLE;
          end
        endcase
      end

      BRW: begin
        if (br_cnt_q == 3'd1) begin
          state_d = RUN;
          en_d    = EN_ALL;
        end else begin
          br_cnt_d = br_cnt_q - 3'd1;
          if (br_cnt_q == 3'd2) begin
            en_d[4] = 1'b1;
            br_d    = taken;
          end
        end
      end

      default: state_d = FILL;
    endcase
  end

  assign pipe.enable_updatePC  = en_q[4];
  assign pipe.enable_fetch     = en_q[3];
  assign pipe.enable_decode    = en_q[2];
  assign pipe.enable_execute   = en_q[1];
  assign pipe.enable_writeback = en_q[0];
  assign pipe.br_taken         = br_q;
  assign pipe.mem_state        = mem_q;

endmodule

// File: tb/tb_lc3_pipe_controller.sv
// tb_lc3_pipe_controller
//   Directed bench for lc3_pipe_controller with BR_BUBBLES = 2.
//   Inputs change and outputs are sampled 1 ns after each rising edge.
//   The enable view is packed {0,0,updatePC,fetch,decode,execute,writeback,br_taken}.
module tb_lc3_pipe_controller;
  logic clock = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [7:0] EN_ZERO = 8'h00;
  localparam logic [7:0] EN_K0   = 8'h30;  // updatePC, fetch
  localparam logic [7:0] EN_K1   = 8'h38;  // + decode
  localparam logic [7:0] EN_K2   = 8'h3C;  // + execute
  localparam logic [7:0] EN_RUN  = 8'h3E;  // + writeback
  localparam logic [7:0] EN_WB   = 8'h02;  // writeback only
  localparam logic [7:0] EN_UPD  = 8'h20;  // updatePC only
  localparam logic [7:0] EN_BRT  = 8'h21;  // updatePC + br_taken

  localparam logic [15:0] I_ADD = 16'h1000;
  localparam logic [15:0] I_LD  = 16'h2000;
  localparam logic [15:0] I_LDR = 16'h6000;
  localparam logic [15:0] I_LDI = 16'hA000;
  localparam logic [15:0] I_STI = 16'hB000;
  localparam logic [15:0] I_BRZ = 16'h0400;
  localparam logic [15:0] I_JMP = 16'hC1C0;

  lc3_pipe_if pipe ();

  lc3_pipe_controller #(.BR_BUBBLES(2)) dut (
    .clock (clock),
    .reset (reset),
    .pipe  (pipe)
  );

  always #5 clock = ~clock;

  logic [7:0] en_obs;
  logic [7:0] mem_obs;
  assign en_obs  = {2'b00, pipe.enable_updatePC, pipe.enable_fetch, pipe.enable_decode,
                    pipe.enable_execute, pipe.enable_writeback, pipe.br_taken};
  assign mem_obs = {6'b0, pipe.mem_state};

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %02h expected %02h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] fill_exp [6];
    logic [7:0] sti_mem  [6];
    fill_exp = '{EN_K0, EN_K1, EN_K2, EN_RUN, EN_RUN, EN_RUN};
    sti_mem  = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd3};

    reset              = 1'b1;
    pipe.ir_e          = I_ADD;
    pipe.nzp_e         = 3'b000;
    pipe.psr           = 3'b000;
    pipe.complete_data = 1'b0;
    tick();
    tick();
    check("reset_en", en_obs, EN_ZERO);
    check("reset_mem", mem_obs, 8'd3);

    // Fill with ALU ops in execute
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("fill_en_k%0d", k), en_obs, fill_exp[k]);
      check($sformatf("fill_mem_k%0d", k), mem_obs, 8'd3);
    end

    // LDR: memory completes on the 4th READ cycle
    pipe.ir_e = I_LDR;
    tick();
    pipe.ir_e = I_ADD;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ldr_en_%0d", i), en_obs, EN_ZERO);
      check($sformatf("ldr_mem_%0d", i), mem_obs, 8'd0);
      if (i == 4) pipe.complete_data = 1'b1;
      tick();
    end
    check("ldr_done_en", en_obs, EN_WB);
    check("ldr_done_mem", mem_obs, 8'd3);
    tick();
    pipe.complete_data = 1'b0;
    check("ldr_resume_en", en_obs, EN_RUN);
    check("ldr_resume_mem", mem_obs, 8'd3);

    // STI: indirect handshake at cycle 2, write handshake at cycle 5
    pipe.ir_e = I_STI;
    tick();
    pipe.ir_e = I_ADD;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("sti_mem_%0d", i + 1), mem_obs, sti_mem[i]);
      check($sformatf("sti_en_%0d", i + 1), en_obs, EN_ZERO);
      pipe.complete_data = (i == 1) || (i == 4);
      tick();
    end
    pipe.complete_data = 1'b0;
    check("sti_resume_en", en_obs, EN_RUN);

    // BR z with Z set: taken
    pipe.nzp_e = 3'b010;
    pipe.psr   = 3'b010;
    pipe.ir_e  = I_BRZ;
    tick();
    pipe.ir_e = I_ADD;
    check("br_t_c1", en_obs, EN_WB);
    tick();
    check("br_t_c2", en_obs, EN_BRT);
    tick();
    check("br_t_resume", en_obs, EN_RUN);

    // BR z with N set: not taken
    pipe.psr  = 3'b100;
    pipe.ir_e = I_BRZ;
    tick();
    pipe.ir_e = I_ADD;
    check("br_nt_c1", en_obs, EN_WB);
    tick();
    check("br_nt_c2", en_obs, EN_UPD);
    tick();
    check("br_nt_resume", en_obs, EN_RUN);
    pipe.nzp_e = 3'b000;

    // JMP then LD back-to-back
    pipe.nzp_e = 3'b111;
    pipe.psr   = 3'b001;
    pipe.ir_e  = I_JMP;
    tick();
    pipe.ir_e = I_LD;
    check("jmp_c1", en_obs, EN_WB);
    tick();
    check("jmp_c2", en_obs, EN_BRT);
    tick();
    pipe.nzp_e = 3'b000;
    check("jmp_resume_en", en_obs, EN_RUN);
    tick();
    check("ld_en", en_obs, EN_ZERO);
    check("ld_mem", mem_obs, 8'd0);
    pipe.complete_data = 1'b1;
    tick();
    pipe.complete_data = 1'b0;
    pipe.ir_e = I_LDI;
    check("ld_done_en", en_obs, EN_WB);
    tick();
    check("ldi_pre_en", en_obs, EN_RUN);
    tick();
    pipe.ir_e = I_ADD;
    check("ldi_mem_1", mem_obs, 8'd1);
    tick();
    check("ldi_mem_2", mem_obs, 8'd1);

    // Reset in the middle of an indirect access, with a handshake pending
    reset              = 1'b1;
    pipe.complete_data = 1'b1;
    tick();
    reset              = 1'b0;
    pipe.complete_data = 1'b0;
    check("mreset_en", en_obs, EN_ZERO);
    check("mreset_mem", mem_obs, 8'd3);
    tick();
    check("refill_k0_en", en_obs, EN_K0);
    check("refill_k0_mem", mem_obs, 8'd3);
    tick();
    check("refill_k1_en", en_obs, EN_K1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
